// File: rtl/artec_axis_arb_packer.sv
// artec_axis_arb_packer: round-robin AXI-Stream arbiter that grants one whole packet
// at a time and packs IN_DW-bit beats into OUT_DW-bit words tagged with the source
// channel. A packet longer than MAX_BEATS is cut, and err_trunc pulses once for the cut.
module artec_axis_arb_packer #(
    parameter int unsigned NCH       = 6,
    parameter int unsigned IN_DW     = 64,
    parameter int unsigned OUT_DW    = 128,
    parameter int unsigned UW        = 5,
    parameter int unsigned MAX_BEATS = 256,
    parameter int unsigned CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_en,
    input  logic [NCH-1:0]          i_s_tvalid,
    output logic [NCH-1:0]          o_s_tready,
    input  logic [NCH*IN_DW-1:0]    i_s_tdata,
    input  logic [NCH*IN_DW/8-1:0]  i_s_tkeep,
    input  logic [NCH*UW-1:0]       i_s_tuser,
    input  logic [NCH-1:0]          i_s_tlast,
    output logic                    o_m_tvalid,
    input  logic                    i_m_tready,
    output logic [OUT_DW-1:0]       o_m_tdata,
    output logic [OUT_DW/8-1:0]     o_m_tkeep,
    output logic [UW-1:0]           o_m_tuser,
    output logic [CW-1:0]           o_m_tid,
    output logic                    o_m_tlast,
    output logic                    o_err_trunc,
    output logic [CW-1:0]           o_err_ch
);

    localparam int unsigned RATIO = OUT_DW / IN_DW;
    localparam int unsigned IN_KW = IN_DW / 8;
    localparam int unsigned LCW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned BCW   = $clog2(MAX_BEATS + 1);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e                r_state;
    logic [CW-1:0]         r_grant;
    logic [CW-1:0]         r_rr_ptr;
    logic [LCW-1:0]        r_lc;
    logic [BCW-1:0]        r_bc;
    logic                  r_m_tvalid;
    logic [OUT_DW-1:0]     r_m_tdata;
    logic [OUT_DW/8-1:0]   r_m_tkeep;
    logic [UW-1:0]         r_m_tuser;
    logic [CW-1:0]         r_m_tid;
    logic                  r_m_tlast;
    logic                  r_err_trunc;
    logic [CW-1:0]         r_err_ch;

    logic                  w_req_any;
    logic [CW-1:0]         w_next_ch;
    logic [CW-1:0]         w_idx;
    logic                  w_room;
    logic                  w_accept;
    logic [IN_DW-1:0]      w_g_data;
    logic [IN_KW-1:0]      w_g_keep;
    logic [UW-1:0]         w_g_user;
    logic                  w_g_last;
    logic                  w_trunc_pt;
    logic                  w_eff_last;
    logic                  w_complete;
    logic [OUT_DW-1:0]     w_data_nxt;
    logic [OUT_DW/8-1:0]   w_keep_nxt;

    // Round-robin pick: nearest requesting channel strictly after r_rr_ptr.
    // Walk the distance downwards so the closest request is the last one written.
    always_comb begin
        w_req_any = 1'b0;
        w_next_ch = r_rr_ptr;
        w_idx     = '0;
        for (int i = NCH; i >= 1; i--) begin
            w_idx = CW'((int'(r_rr_ptr) + i) % NCH);
            if (i_s_tvalid[w_idx]) begin
                w_req_any = 1'b1;
                w_next_ch = w_idx;
            end
        end
    end

    // Select the granted channel's beat and decide whether it ends a word or a packet.
    always_comb begin
        w_room     = !r_m_tvalid || i_m_tready;
        w_accept   = (r_state == StXfer) && i_s_tvalid[r_grant] && w_room;
        w_g_data   = i_s_tdata[int'(r_grant) * IN_DW +: IN_DW];
        w_g_keep   = i_s_tkeep[int'(r_grant) * IN_KW +: IN_KW];
        w_g_user   = i_s_tuser[int'(r_grant) * UW +: UW];
        w_g_last   = i_s_tlast[r_grant];
        w_trunc_pt = (r_bc == BCW'(MAX_BEATS - 1));
        w_eff_last = w_g_last || w_trunc_pt;
        w_complete = (r_lc == LCW'(RATIO - 1)) || w_eff_last;
    end

    // Lane merge; the first beat of a word wipes the stale word so unfilled lanes read 0.
    always_comb begin
        w_data_nxt = (r_lc == '0) ? '0 : r_m_tdata;
        w_keep_nxt = (r_lc == '0) ? '0 : r_m_tkeep;
        w_data_nxt[int'(r_lc) * IN_DW +: IN_DW] = w_g_data;
        w_keep_nxt[int'(r_lc) * IN_KW +: IN_KW] = w_g_keep;
    end

    // Only the granted channel sees ready, and only while the output register can take a beat.
    always_comb begin
        o_s_tready = '0;
        if (r_state == StXfer) begin
            o_s_tready[r_grant] = w_room;
        end
    end

    // Arbitration FSM, packing counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= StIdle;
            r_grant     <= '0;
            r_rr_ptr    <= CW'(NCH - 1);
            r_lc        <= '0;
            r_bc        <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tdata   <= '0;
            r_m_tkeep   <= '0;
            r_m_tuser   <= '0;
            r_m_tid     <= '0;
            r_m_tlast   <= 1'b0;
            r_err_trunc <= 1'b0;
            r_err_ch    <= '0;
        end else begin
            r_err_trunc <= 1'b0;
            if (r_m_tvalid && i_m_tready) begin
                r_m_tvalid <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    if (i_en && w_req_any) begin
                        r_grant  <= w_next_ch;
                        r_rr_ptr <= w_next_ch;
                        r_state  <= StXfer;
                    end
                end
                StXfer: begin
                    if (w_accept) begin
                        r_m_tdata <= w_data_nxt;
                        r_m_tkeep <= w_keep_nxt;
                        if (w_complete) begin
                            // Set after the drain above, so a word can leave and arrive together.
                            r_m_tvalid <= 1'b1;
                            r_lc       <= '0;
                            r_m_tid    <= r_grant;
                            r_m_tlast  <= w_eff_last;
                            r_m_tuser  <= w_g_user;
                        end else begin
                            r_lc <= r_lc + 1'b1;
                        end
                        if (w_eff_last) begin
                            r_bc    <= '0;
                            r_state <= StIdle;
                        end else begin
                            r_bc <= r_bc + 1'b1;
                        end
                        if (w_trunc_pt && !w_g_last) begin
                            r_err_trunc <= 1'b1;
                            r_err_ch    <= r_grant;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_m_tvalid  = r_m_tvalid;
    assign o_m_tdata   = r_m_tdata;
    assign o_m_tkeep   = r_m_tkeep;
    assign o_m_tuser   = r_m_tuser;
    assign o_m_tid     = r_m_tid;
    assign o_m_tlast   = r_m_tlast;
    assign o_err_trunc = r_err_trunc;
    assign o_err_ch    = r_err_ch;

endmodule

// File: tb/tb_artec_axis_arb_packer.sv
// Bench for artec_axis_arb_packer: per-channel source queues, a packet-level reference
// model that packs whole packets in round-robin order, and directed plus random scenarios.
module tb_artec_axis_arb_packer;

    localparam int NCH = 6, IN_DW = 64, OUT_DW = 128, UW = 5, MAXB = 4, CW = 3;
    localparam int RATIO = OUT_DW / IN_DW, KW = IN_DW / 8;

    typedef struct packed {
        logic [IN_DW-1:0] data;
        logic [KW-1:0]    keep;
        logic [UW-1:0]    user;
        logic             last;
    } beat_t;

    typedef struct packed {
        logic [OUT_DW-1:0]   data;
        logic [OUT_DW/8-1:0] keep;
        logic [UW-1:0]       user;
        logic [CW-1:0]       tid;
        logic                last;
    } word_t;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   en = 1'b0;
    logic [NCH-1:0]         s_tvalid = '0;
    logic [NCH-1:0]         s_tready;
    logic [NCH*IN_DW-1:0]   s_tdata = '0;
    logic [NCH*KW-1:0]      s_tkeep = '0;
    logic [NCH*UW-1:0]      s_tuser = '0;
    logic [NCH-1:0]         s_tlast = '0;
    logic                   m_tvalid;
    logic                   m_tready = 1'b1;
    logic [OUT_DW-1:0]      m_tdata;
    logic [OUT_DW/8-1:0]    m_tkeep;
    logic [UW-1:0]          m_tuser;
    logic [CW-1:0]          m_tid;
    logic                   m_tlast;
    logic                   err_trunc;
    logic [CW-1:0]          err_ch;

    beat_t          src_q [NCH][$];
    word_t          out_q [$];
    word_t          exp_q [$];
    logic [CW-1:0]  err_q [$];
    logic [CW-1:0]  exp_err_q [$];
    logic [NCH-1:0] acc_hist [$];
    logic           mval_hist [$];
    int             viol;
    int             rdy_mode;
    logic           prev_stall;
    word_t          prev_word;
    int             passed = 0;
    int             total = 0;

    artec_axis_arb_packer #(
        .NCH       (NCH),
        .IN_DW     (IN_DW),
        .OUT_DW    (OUT_DW),
        .UW        (UW),
        .MAX_BEATS (MAXB),
        .CW        (CW)
    ) u_dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_en        (en),
        .i_s_tvalid  (s_tvalid),
        .o_s_tready  (s_tready),
        .i_s_tdata   (s_tdata),
        .i_s_tkeep   (s_tkeep),
        .i_s_tuser   (s_tuser),
        .i_s_tlast   (s_tlast),
        .o_m_tvalid  (m_tvalid),
        .i_m_tready  (m_tready),
        .o_m_tdata   (m_tdata),
        .o_m_tkeep   (m_tkeep),
        .o_m_tuser   (m_tuser),
        .o_m_tid     (m_tid),
        .o_m_tlast   (m_tlast),
        .o_err_trunc (err_trunc),
        .o_err_ch    (err_ch)
    );

    always #5 clk = ~clk;

    function automatic beat_t mk_beat(input logic last, input logic [KW-1:0] keep);
        beat_t b;
        b.data = {$urandom, $urandom};
        b.keep = keep;
        b.user = UW'($urandom);
        b.last = last;
        return b;
    endfunction

    function automatic bit pending();
        for (int c = 0; c < NCH; c++) if (src_q[c].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load_packet(input int ch, input int len);
        for (int b = 0; b < len; b++) src_q[ch].push_back(mk_beat(b == len - 1, 8'hFF));
    endtask

    // Reference model: whole packets in round-robin order, each cut at MAXB beats, packed
    // RATIO beats per word, last word of a packet may be partial with zero upper lanes.
    task automatic build_expected();
        beat_t q [NCH][$];
        int rr;
        exp_q.delete();
        exp_err_q.delete();
        for (int c = 0; c < NCH; c++) q[c] = src_q[c];
        rr = NCH - 1;
        while (1) begin
            int ch;
            int n;
            int lane;
            bit done;
            word_t w;
            beat_t b;
            ch = -1;
            for (int i = 1; i <= NCH; i++) begin
                if (ch < 0 && q[(rr + i) % NCH].size() != 0) ch = (rr + i) % NCH;
            end
            if (ch < 0) break;
            rr = ch;
            n = 0;
            lane = 0;
            done = 1'b0;
            w = '0;
            while (!done && q[ch].size() != 0) begin
                b = q[ch].pop_front();
                n++;
                if (lane == 0) begin
                    w.data = '0;
                    w.keep = '0;
                end
                w.data[lane*IN_DW +: IN_DW] = b.data;
                w.keep[lane*KW +: KW] = b.keep;
                done = b.last || (n == MAXB);
                if (n == MAXB && !b.last) exp_err_q.push_back(CW'(ch));
                if (lane == RATIO - 1 || done) begin
                    w.user = b.user;
                    w.tid  = CW'(ch);
                    w.last = done;
                    exp_q.push_back(w);
                    lane = 0;
                end else begin
                    lane++;
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, retire accepted beats.
    task automatic cycle();
        logic [NCH-1:0] acc;
        word_t cur;
        for (int c = 0; c < NCH; c++) begin
            s_tvalid[c] = (src_q[c].size() != 0);
            if (src_q[c].size() != 0) begin
                s_tdata[c*IN_DW +: IN_DW] = src_q[c][0].data;
                s_tkeep[c*KW +: KW]       = src_q[c][0].keep;
                s_tuser[c*UW +: UW]       = src_q[c][0].user;
                s_tlast[c]                = src_q[c][0].last;
            end else begin
                s_tlast[c] = 1'b0;
            end
        end
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
        #1;
        cur.data = m_tdata;
        cur.keep = m_tkeep;
        cur.user = m_tuser;
        cur.tid  = m_tid;
        cur.last = m_tlast;
        if (prev_stall && (!m_tvalid || cur !== prev_word)) viol++;
        if (m_tvalid && !m_tready && s_tready !== '0) viol++;
        if ($countones(s_tready) > 1) viol++;
        acc = s_tvalid & s_tready;
        acc_hist.push_back(acc);
        mval_hist.push_back(m_tvalid);
        if (m_tvalid && m_tready) out_q.push_back(cur);
        if (err_trunc) err_q.push_back(err_ch);
        prev_stall = m_tvalid && !m_tready;
        prev_word  = cur;
        @(negedge clk);
        for (int c = 0; c < NCH; c++) if (acc[c]) void'(src_q[c].pop_front());
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && (pending() || out_q.size() < exp_q.size())) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
    endtask

    task automatic reset_sys();
        rstn = 1'b0;
        en = 1'b1;
        rdy_mode = 0;
        s_tvalid = '0;
        s_tlast = '0;
        m_tready = 1'b1;
        for (int c = 0; c < NCH; c++) src_q[c].delete();
        out_q.delete();
        err_q.delete();
        acc_hist.delete();
        mval_hist.delete();
        viol = 0;
        prev_stall = 1'b0;
        prev_word = '0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        en = 1'b1;
        s_tvalid = '1;
        s_tlast = '0;
        m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (s_tready !== '0) $display("FAIL reset_tready got %b want 0", s_tready);
        else passed++;
        total++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tuser, m_tid, m_tlast} !== '0)
            $display("FAIL reset_mout got v=%b d=%h k=%h u=%h id=%0d l=%b want all 0",
                     m_tvalid, m_tdata, m_tkeep, m_tuser, m_tid, m_tlast);
        else passed++;
        total++;
        if ({err_trunc, err_ch} !== '0)
            $display("FAIL reset_err got %b/%0d want 0/0", err_trunc, err_ch);
        else passed++;
        @(negedge clk);
        s_tvalid = '0;
    endtask

    task automatic test_single_packet();
        int first_v;
        reset_sys();
        load_packet(0, 4);
        build_expected();
        drain(100);
        total++;
        if (out_q.size() != exp_q.size())
            $display("FAIL single_count got %0d want %0d", out_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_q[i])
                $display("FAIL single_word%0d got %h want %h", i, out_q[i], exp_q[i]);
            else passed++;
        end
        total++;
        if (acc_hist[0][0] !== 1'b0 || acc_hist[1][0] !== 1'b1)
            $display("FAIL grant_latency got %b,%b want 0,1", acc_hist[0][0], acc_hist[1][0]);
        else passed++;
        first_v = -1;
        for (int i = 0; i < mval_hist.size(); i++) if (first_v < 0 && mval_hist[i]) first_v = i;
        total++;
        if (first_v != 3) $display("FAIL out_latency got %0d want 3", first_v);
        else passed++;
        total++;
        if (err_q.size() != 0 || viol != 0)
            $display("FAIL single_err got errs=%0d viol=%0d want 0/0", err_q.size(), viol);
        else passed++;
    endtask

    task automatic test_short_packet();
        reset_sys();
        load_packet(2, 3);
        build_expected();
        drain(100);
        total++;
        if (out_q.size() != exp_q.size())
            $display("FAIL short_count got %0d want %0d", out_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_q[i])
                $display("FAIL short_word%0d got %h want %h", i, out_q[i], exp_q[i]);
            else passed++;
        end
        if (out_q.size() == 2) begin
            total++;
            if (out_q[1].keep !== 16'h00FF || out_q[1].data[127:64] !== 64'h0)
                $display("FAIL short_partial got keep=%h hi=%h want 00ff/0",
                         out_q[1].keep, out_q[1].data[127:64]);
            else passed++;
        end
    endtask

    task automatic test_round_robin();
        int fa;
        int la;
        reset_sys();
        for (int p = 0; p < 2; p++) begin
            load_packet(0, 2);
            load_packet(1, 2);
            load_packet(5, 2);
        end
        build_expected();
        drain(200);
        total++;
        if (out_q.size() != exp_q.size())
            $display("FAIL rr_count got %0d want %0d", out_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_q[i])
                $display("FAIL rr_word%0d got tid=%0d %h want tid=%0d %h",
                         i, out_q[i].tid, out_q[i], exp_q[i].tid, exp_q[i]);
            else passed++;
        end
        fa = -1;
        la = -1;
        for (int i = 0; i < acc_hist.size(); i++) begin
            if (acc_hist[i] != '0) begin
                if (fa < 0) fa = i;
                la = i;
            end
        end
        // 12 beats plus one idle bubble between each of the 6 packets.
        total++;
        if (fa != 1 || la - fa + 1 != 17)
            $display("FAIL rr_bubbles got first=%0d span=%0d want 1/17", fa, la - fa + 1);
        else passed++;
    endtask

    task automatic test_truncation();
        reset_sys();
        load_packet(3, 6);
        build_expected();
        drain(100);
        total++;
        if (out_q.size() != 3 || out_q.size() != exp_q.size())
            $display("FAIL trunc_count got %0d want 3", out_q.size());
        else passed++;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_q[i])
                $display("FAIL trunc_word%0d got %h want %h", i, out_q[i], exp_q[i]);
            else passed++;
        end
        total++;
        if (err_q.size() != 1 || err_q[0] !== 3'd3)
            $display("FAIL trunc_pulse got n=%0d ch=%0d want 1/3", err_q.size(), err_q[0]);
        else passed++;
        total++;
        if (err_ch !== 3'd3) $display("FAIL trunc_held got %0d want 3", err_ch);
        else passed++;
    endtask

    task automatic test_backpressure();
        reset_sys();
        rdy_mode = 1;
        load_packet(1, 8);
        build_expected();
        drain(200);
        total++;
        if (out_q.size() != exp_q.size())
            $display("FAIL bp_count got %0d want %0d", out_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_q[i])
                $display("FAIL bp_word%0d got %h want %h", i, out_q[i], exp_q[i]);
            else passed++;
        end
        total++;
        if (viol != 0) $display("FAIL bp_stall got %0d violations want 0", viol);
        else passed++;
    endtask

    task automatic test_enable_gate();
        int n;
        int ch1_acc;
        reset_sys();
        load_packet(4, 3);
        build_expected();
        n = 0;
        do begin
            cycle();
            n++;
        end while (acc_hist[$][4] !== 1'b1 && n < 10);
        en = 1'b0;
        load_packet(1, 2);
        repeat (15) cycle();
        total++;
        if (out_q.size() != exp_q.size())
            $display("FAIL en_inflight got %0d words want %0d", out_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_q[i])
                $display("FAIL en_word%0d got %h want %h", i, out_q[i], exp_q[i]);
            else passed++;
        end
        ch1_acc = 0;
        foreach (acc_hist[i]) if (acc_hist[i][1]) ch1_acc++;
        total++;
        if (ch1_acc != 0 || src_q[1].size() != 2)
            $display("FAIL en_block got acc=%0d left=%0d want 0/2", ch1_acc, src_q[1].size());
        else passed++;
        en = 1'b1;
        out_q.delete();
        build_expected();
        drain(100);
        total++;
        if (out_q.size() != 1 || out_q[0] !== exp_q[0])
            $display("FAIL en_resume got n=%0d %h want 1 %h", out_q.size(), out_q[0], exp_q[0]);
        else passed++;
    endtask

    task automatic test_reset_mid_packet();
        int n;
        reset_sys();
        load_packet(3, 3);
        n = 0;
        do begin
            cycle();
            n++;
        end while (acc_hist[$][3] !== 1'b1 && n < 10);
        rstn = 1'b0;
        #1;
        total++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tuser, m_tid, m_tlast, s_tready} !== '0)
            $display("FAIL midrst_out got v=%b d=%h k=%h rdy=%b want all 0",
                     m_tvalid, m_tdata, m_tkeep, s_tready);
        else passed++;
        @(negedge clk);
        for (int c = 0; c < NCH; c++) src_q[c].delete();
        s_tvalid = '0;
        out_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        load_packet(5, 1);
        load_packet(0, 1);
        build_expected();
        drain(100);
        total++;
        if (out_q.size() != 2 || out_q[0].tid !== 3'd0)
            $display("FAIL midrst_first got n=%0d tid=%0d want 2/0", out_q.size(), out_q[0].tid);
        else passed++;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_q[i])
                $display("FAIL midrst_word%0d got %h want %h", i, out_q[i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int n;
            reset_sys();
            rdy_mode = 2;
            for (int c = 0; c < NCH; c++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    int len;
                    len = $urandom_range(1, 7);
                    for (int b = 0; b < len; b++)
                        src_q[c].push_back(mk_beat(b == len - 1, KW'($urandom)));
                end
            end
            build_expected();
            n = 0;
            while (n < 3000 && (pending() || out_q.size() < exp_q.size())) begin
                en = ($urandom_range(0, 3) != 0);
                cycle();
                n++;
            end
            en = 1'b1;
            repeat (4) cycle();
            total++;
            if (out_q.size() != exp_q.size())
                $display("FAIL rand%0d_count got %0d want %0d", it, out_q.size(), exp_q.size());
            else passed++;
            for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
                total++;
                if (out_q[i] !== exp_q[i])
                    $display("FAIL rand%0d_word%0d got %h want %h", it, i, out_q[i], exp_q[i]);
                else passed++;
            end
            total++;
            if (err_q.size() != exp_err_q.size())
                $display("FAIL rand%0d_errs got %0d want %0d", it, err_q.size(), exp_err_q.size());
            else passed++;
            for (int i = 0; i < err_q.size() && i < exp_err_q.size(); i++) begin
                total++;
                if (err_q[i] !== exp_err_q[i])
                    $display("FAIL rand%0d_errch%0d got %0d want %0d", it, i, err_q[i], exp_err_q[i]);
                else passed++;
            end
            total++;
            if (viol != 0) $display("FAIL rand%0d_stall got %0d violations want 0", it, viol);
            else passed++;
        end
    endtask

    initial begin
        rdy_mode = 0;
        viol = 0;
        prev_stall = 1'b0;
        prev_word = '0;
        @(negedge clk);
        test_reset();
        test_single_packet();
        test_short_packet();
        test_round_robin();
        test_truncation();
        test_backpressure();
        test_enable_gate();
        test_reset_mid_packet();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
